pwm_capture: RTL and testbench

//  Receive side of the LevelX gate-drive pair S[1:0]: measures per-carrier-period high time, period and

---
 rtl/pwm_capture.sv | 146 ++++++++++++++
 tb/tb_pwm_capture.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - Complementary PWM pair receiver: high time, period, dead-time minimum, fault flags.
module pwm_capture #(
  parameter int Width        = 16,
  parameter int SyncStages   = 2,
  parameter int TimeoutCount = 65535
) (
  input  logic             MClk,
  input  logic             Rst,
  input  logic [1:0]       S,
  input  logic             ClearFault,
  output logic [Width-1:0] HighCount,
  output logic [Width-1:0] PeriodCount,
  output logic [Width-1:0] DeadMin,
  output logic             Valid,
  output logic             Saturated,
  output logic             ShootThrough,
  output logic             LossOfSignal
);

  localparam logic [Width-1:0] MaxCnt     = '1;
  localparam logic [Width-1:0] TimeoutVal = Width'(TimeoutCount);
  localparam int               PrimeMax   = SyncStages + 2;
  localparam int               PW         = $clog2(PrimeMax + 1);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  logic [1:0]       sync_q [SyncStages];
  logic [1:0]       lvl_q, prev_q;
  logic [PW-1:0]    prime_q;
  state_t           state_q;
  logic [Width-1:0] hi_q, per_q, gap_q, dmin_q, idle_q;
  logic             gap_arm_q, gap_src_q, gap_seen_q;

  logic             primed, both_low, gap_done, timeout;
  logic [1:0]       rise, fall;
  logic [Width-1:0] min_in;

  function automatic logic [Width-1:0] sat_inc(input logic [Width-1:0] v);
    return (v == MaxCnt) ? v : v + Width'(1);
  endfunction

  // Edges are ignored until the pipeline behind reset holds real pin samples,
  // so a pin already high at reset release is not mistaken for a rise.
  always_comb begin
    primed   = (prime_q == PW'(PrimeMax));
    rise     = primed ? (lvl_q & ~prev_q) : 2'b00;
    fall     = primed ? (~lvl_q & prev_q) : 2'b00;
    both_low = (lvl_q == 2'b00);
    gap_done = gap_arm_q && ((rise[0] && gap_src_q) || (rise[1] && !gap_src_q));
    min_in   = (gap_q < dmin_q) ? gap_q : dmin_q;
    timeout  = !rise[0] && (idle_q == TimeoutVal - Width'(1));
  end

  always_ff @(posedge MClk) begin
    if (Rst) begin
      for (int i = 0; i < SyncStages; i++) sync_q[i] <= 2'b00;
      lvl_q        <= 2'b00;
      prev_q       <= 2'b00;
      prime_q      <= '0;
      state_q      <= IDLE;
      hi_q         <= '0;
      per_q        <= '0;
      gap_q        <= '0;
      dmin_q       <= '1;
      idle_q       <= '0;
      gap_arm_q    <= 1'b0;
      gap_src_q    <= 1'b0;
      gap_seen_q   <= 1'b0;
      HighCount    <= '0;
      PeriodCount  <= '0;
      DeadMin      <= '0;
      Valid        <= 1'b0;
      Saturated    <= 1'b0;
      ShootThrough <= 1'b0;
      LossOfSignal <= 1'b0;
    end else begin
      sync_q[0] <= S;
      for (int i = 1; i < SyncStages; i++) sync_q[i] <= sync_q[i-1];
      lvl_q  <= sync_q[SyncStages-1];
      prev_q <= lvl_q;
      if (!primed) prime_q <= prime_q + PW'(1);

      Valid <= 1'b0;

      if (lvl_q == 2'b11)  ShootThrough <= 1'b1;
      else if (ClearFault) ShootThrough <= 1'b0;

      if (rise[0])                  idle_q <= '0;
      else if (idle_q != TimeoutVal) idle_q <= idle_q + Width'(1);

      if (timeout)         LossOfSignal <= 1'b1;
      else if (ClearFault) LossOfSignal <= 1'b0;

      // Gap tracking runs independently of the FSM so a gap crossing a
      // period boundary is credited to the period its closing rise starts.
      if (rise != 2'b00) begin
        gap_arm_q <= 1'b0;
        gap_q     <= '0;
      end else if (fall != 2'b00 && both_low) begin
        gap_arm_q <= 1'b1;
        gap_src_q <= fall[1];
        gap_q     <= Width'(1);
      end else if (gap_arm_q && both_low) begin
        gap_q <= sat_inc(gap_q);
      end

      case (state_q)
        IDLE: begin
          if (rise[0]) begin
            state_q    <= HIGH;
            hi_q       <= Width'(1);
            per_q      <= Width'(1);
            dmin_q     <= gap_done ? gap_q : MaxCnt;
            gap_seen_q <= gap_done;
          end
        end
        default: begin
          if (timeout) begin
            state_q <= IDLE;
          end else if (rise[0]) begin
            HighCount   <= hi_q;
            PeriodCount <= per_q;
            DeadMin     <= gap_seen_q ? dmin_q : '0;
            Saturated   <= (hi_q == MaxCnt) || (per_q == MaxCnt) ||
                           (gap_seen_q && dmin_q == MaxCnt);
            Valid       <= 1'b1;
            state_q     <= HIGH;
            hi_q        <= Width'(1);
            per_q       <= Width'(1);
            dmin_q      <= gap_done ? gap_q : MaxCnt;
            gap_seen_q  <= gap_done;
          end else begin
            per_q <= sat_inc(per_q);
            if (lvl_q[0]) hi_q <= sat_inc(hi_q);
            if (state_q == HIGH && fall[0]) state_q <= LOW;
            if (gap_done) begin
              dmin_q     <= min_in;
              gap_seen_q <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - Directed vector bench for pwm_capture (16-bit and 8-bit instances).
module tb_pwm_capture;

  logic        MClk = 1'b0;
  always #5 MClk = ~MClk;

  logic        Rst, ClearFault, ClearFault8;
  logic [1:0]  S, S8;
  logic [15:0] HighCount, PeriodCount, DeadMin;
  logic        Valid, Saturated, ShootThrough, LossOfSignal;
  logic [7:0]  HighCount8, PeriodCount8, DeadMin8;
  logic        Valid8, Saturated8, ShootThrough8, LossOfSignal8;

  pwm_capture #(.Width(16), .SyncStages(2), .TimeoutCount(1000)) u_dut (
    .MClk(MClk), .Rst(Rst), .S(S), .ClearFault(ClearFault),
    .HighCount(HighCount), .PeriodCount(PeriodCount), .DeadMin(DeadMin),
    .Valid(Valid), .Saturated(Saturated), .ShootThrough(ShootThrough),
    .LossOfSignal(LossOfSignal)
  );

  pwm_capture #(.Width(8), .SyncStages(2), .TimeoutCount(255)) u_dut8 (
    .MClk(MClk), .Rst(Rst), .S(S8), .ClearFault(ClearFault8),
    .HighCount(HighCount8), .PeriodCount(PeriodCount8), .DeadMin(DeadMin8),
    .Valid(Valid8), .Saturated(Saturated8), .ShootThrough(ShootThrough8),
    .LossOfSignal(LossOfSignal8)
  );

  typedef struct {
    bit which;
    int hi, g1, s1, g2, n;
    int exp_valid, exp_hi, exp_per, exp_dmin, exp_sat;
  } vec_t;

  vec_t vecs[8];
  int   total = 0;
  int   bad   = 0;

  int vcnt = 0, cap_hi = 0, cap_per = 0, cap_dmin = 0, cap_sat = 0;
  int vcnt8 = 0, cap_hi8 = 0, cap_per8 = 0, cap_dmin8 = 0, cap_sat8 = 0;

  always @(negedge MClk) begin
    if (Valid) begin
      vcnt++;
      cap_hi = HighCount; cap_per = PeriodCount; cap_dmin = DeadMin; cap_sat = Saturated;
    end
    if (Valid8) begin
      vcnt8++;
      cap_hi8 = HighCount8; cap_per8 = PeriodCount8; cap_dmin8 = DeadMin8; cap_sat8 = Saturated8;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input bit which, input logic [1:0] v, input int n);
    if (which) S8 = v; else S = v;
    repeat (n) @(negedge MClk);
    #1;
  endtask

  task automatic run_period(input bit which, input int hi, input int g1, input int s1, input int g2);
    drive(which, 2'b01, hi);
    drive(which, 2'b00, g1);
    drive(which, 2'b10, s1);
    drive(which, 2'b00, g2);
  endtask

  initial begin
    int v0;
    //            which hi   g1  s1   g2  n  valid hi   per  dmin sat
    vecs[0] = '{1'b0, 200, 5,  290, 5,  3, 2,    200, 500, 5,  0};
    vecs[1] = '{1'b0, 200, 5,  286, 9,  3, 3,    200, 500, 5,  0};
    vecs[2] = '{1'b0, 100, 5,  386, 9,  3, 3,    100, 500, 5,  0};
    vecs[3] = '{1'b0, 50,  3,  444, 3,  3, 3,    50,  500, 3,  0};
    vecs[4] = '{1'b0, 300, 20, 160, 20, 3, 3,    300, 500, 20, 0};
    vecs[5] = '{1'b0, 120, 4,  272, 4,  3, 3,    120, 400, 4,  0};
    vecs[6] = '{1'b1, 100, 5,  145, 5,  3, 2,    100, 255, 5,  1};
    vecs[7] = '{1'b1, 100, 5,  90,  5,  3, 3,    100, 200, 5,  0};

    Rst = 1'b1; ClearFault = 1'b0; ClearFault8 = 1'b0; S = 2'b10; S8 = 2'b00;
    drive(0, 2'b10, 4);
    Rst = 1'b0;
    drive(0, 2'b10, 1);
    chk("reset HighCount", HighCount, 0);
    chk("reset PeriodCount", PeriodCount, 0);
    chk("reset DeadMin", DeadMin, 0);
    chk("reset Saturated", Saturated, 0);
    chk("reset ShootThrough", ShootThrough, 0);
    chk("reset LossOfSignal", LossOfSignal, 0);
    drive(0, 2'b10, 900);
    chk("steady LoS early", LossOfSignal, 0);
    drive(0, 2'b10, 110);
    chk("steady LoS set", LossOfSignal, 1);
    chk("steady no Valid", vcnt, 0);
    ClearFault = 1'b1;
    drive(0, 2'b10, 1);
    ClearFault = 1'b0;
    drive(0, 2'b10, 1);
    chk("LoS cleared", LossOfSignal, 0);
    drive(0, 2'b00, 10);

    for (int i = 0; i < 6; i++) begin
      v0 = vcnt;
      for (int p = 0; p < vecs[i].n; p++)
        run_period(0, vecs[i].hi, vecs[i].g1, vecs[i].s1, vecs[i].g2);
      chk($sformatf("vec%0d valids", i), vcnt - v0, vecs[i].exp_valid);
      chk($sformatf("vec%0d HighCount", i), cap_hi, vecs[i].exp_hi);
      chk($sformatf("vec%0d PeriodCount", i), cap_per, vecs[i].exp_per);
      chk($sformatf("vec%0d DeadMin", i), cap_dmin, vecs[i].exp_dmin);
      chk($sformatf("vec%0d Saturated", i), cap_sat, vecs[i].exp_sat);
    end
    chk("periodic LoS", LossOfSignal, 0);

    // Single-cycle overlap inside the high phase.
    v0 = vcnt;
    drive(0, 2'b01, 100);
    drive(0, 2'b11, 1);
    drive(0, 2'b01, 99);
    drive(0, 2'b00, 5);
    drive(0, 2'b10, 290);
    drive(0, 2'b00, 5);
    chk("overlap ShootThrough set", ShootThrough, 1);
    run_period(0, 200, 5, 290, 5);
    run_period(0, 200, 5, 290, 5);
    chk("overlap ShootThrough sticky", ShootThrough, 1);
    chk("overlap valids", vcnt - v0, 3);
    chk("overlap HighCount", cap_hi, 200);
    chk("overlap PeriodCount", cap_per, 500);
    chk("overlap DeadMin", cap_dmin, 5);
    ClearFault = 1'b1;
    drive(0, 2'b01, 1);
    ClearFault = 1'b0;
    drive(0, 2'b01, 3);
    chk("ShootThrough cleared", ShootThrough, 0);

    // Reset in the middle of a high phase.
    drive(0, 2'b01, 50);
    Rst = 1'b1;
    drive(0, 2'b01, 1);
    Rst = 1'b0;
    chk("midreset HighCount", HighCount, 0);
    chk("midreset PeriodCount", PeriodCount, 0);
    chk("midreset DeadMin", DeadMin, 0);
    v0 = vcnt;
    drive(0, 2'b01, 145);
    drive(0, 2'b00, 5);
    drive(0, 2'b10, 290);
    drive(0, 2'b00, 5);
    run_period(0, 200, 5, 290, 5);
    chk("midreset first rise no Valid", vcnt - v0, 0);
    drive(0, 2'b01, 3);
    chk("latency before Valid", vcnt - v0, 0);
    drive(0, 2'b01, 1);
    chk("latency Valid", vcnt - v0, 1);
    chk("midreset HighCount pub", cap_hi, 200);
    chk("midreset PeriodCount pub", cap_per, 500);
    chk("midreset DeadMin pub", cap_dmin, 5);
    drive(0, 2'b01, 196);
    drive(0, 2'b00, 5);
    drive(0, 2'b10, 290);
    drive(0, 2'b00, 5);

    // Narrow-width instance: saturation boundary and timeout.
    ClearFault8 = 1'b1;
    drive(1, 2'b00, 1);
    ClearFault8 = 1'b0;
    drive(1, 2'b00, 2);
    chk("w8 LoS cleared", LossOfSignal8, 0);
    for (int i = 6; i < 8; i++) begin
      v0 = vcnt8;
      for (int p = 0; p < vecs[i].n; p++)
        run_period(1, vecs[i].hi, vecs[i].g1, vecs[i].s1, vecs[i].g2);
      chk($sformatf("vec%0d valids", i), vcnt8 - v0, vecs[i].exp_valid);
      chk($sformatf("vec%0d HighCount", i), cap_hi8, vecs[i].exp_hi);
      chk($sformatf("vec%0d PeriodCount", i), cap_per8, vecs[i].exp_per);
      chk($sformatf("vec%0d DeadMin", i), cap_dmin8, vecs[i].exp_dmin);
      chk($sformatf("vec%0d Saturated", i), cap_sat8, vecs[i].exp_sat);
    end
    chk("w8 LoS after 255 period", LossOfSignal8, 0);
    drive(1, 2'b01, 300);
    chk("w8 LoS timeout", LossOfSignal8, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
